mpy_seq_ctrl: RTL and testbench
===============================

Name: mpy_seq_ctrl

Overview:
Operand-issue and result-capture sequencer that wraps the 32x32 signed combinational multiplier (MPY).
- Accepts operand pairs over a valid/ready handshake and registers them.
- Drives the registers onto the multiplier inputs and holds them stable for a programmable settle window.
- Samples the 64-bit product into an output register and presents it over a valid/ready handshake.
- Sits between the issuing datapath (upstream) and MPY; MPY is instantiated beside it, not inside it.

Parameters:
SETTLE_CYCLES, 2, full clock cycles operands are held on mpy_a/mpy_b before product is sampled; legal range 1..255.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept an operand pair.
in_a  input  32  multiplicand, two's complement.
in_b  input  32  multiplier, two's complement.
mpy_a  output  32  registered operand to MPY a.
mpy_b  output  32  registered operand to MPY b.
mpy_product  input  64  MPY product output.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_product  output  64  registered signed product.
out_ovf  output  1  result does not fit in signed 32 bits (see Optional Feature).
busy  output  1  high in SETTLE or DONE.
op_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (async, rst=1): state=IDLE; mpy_a, mpy_b, out_product, op_count, settle counter = 0; out_valid=0; out_ovf=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SETTLE: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Accept occurs when in_valid and in_ready are both high at a rising edge.
  - On accept: mpy_a<=in_a; mpy_b<=in_b; settle counter<=SETTLE_CYCLES-1; state<=SETTLE.
- SETTLE:
  - Counter decrements by 1 per cycle.
  - In the cycle with counter==0: out_product<=mpy_product; out_ovf updated; state<=DONE.
- Latency: accept edge at cycle T gives out_valid=1 from cycle T+SETTLE_CYCLES.
  - SETTLE_CYCLES=1 means exactly one SETTLE cycle.
- DONE with out_ready=0: out_valid, out_product and out_ovf hold; in_valid is ignored.
- DONE with out_ready=1:
  - op_count increments (wraps all-ones to 0).
  - If in_valid is also high: simultaneous accept; next state is SETTLE.
  - Otherwise: next state is IDLE.
- Peak throughput: one op per SETTLE_CYCLES+1 cycles.
- mpy_a/mpy_b change only on an accept edge; they are otherwise stable, including in DONE and IDLE.
- in_a/in_b are sampled only on accept; changes at any other time have no effect.
- out_product is valid only while out_valid=1. It holds its last value after handoff.
- busy = (state != IDLE).
- Reset asserted mid-SETTLE or mid-DONE: immediate return to reset values; no result is produced and op_count is not incremented.
- The block performs no arithmetic on the product. Sign handling belongs entirely to MPY; the 64-bit value is passed through unchanged.

Optional Feature:
Macro MPY_OVF_FLAG_EN.
- Defined: out_ovf is registered with out_product. out_ovf = 1 when mpy_product[63:31] are not all equal (result outside -2^31..2^31-1), else 0.
- Not defined: out_ovf is constant 0; no compare logic is generated; the port still exists.

Test Plan:
- SETTLE_CYCLES=2, MPY attached. in_a=3, in_b=5, single accept at T -> out_valid rises at T+2; out_product=0x000000000000000F; out_ovf=0; op_count=1 after handshake.
- in_a=0xFFFFFFFE (-2), in_b=3 -> out_product=0xFFFFFFFFFFFFFFFA; out_ovf=0.
- in_a=in_b=0x80000000 -> out_product=0x4000000000000000. With MPY_OVF_FLAG_EN, out_ovf=1; without it, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with in_a=7 -> in_ready=0, out_product unchanged, mpy_a unchanged. Raise out_ready -> same-edge accept of 7; next result is valid 2 cycles later.
- Back-to-back: out_ready=1 and in_valid=1 continuously for 4 ops -> one result every 3 cycles; op_count=4.
- Assert rst for 1 cycle mid-SETTLE -> all outputs zero immediately, state IDLE, in_ready=1, no out_valid pulse afterwards.

Source files
------------

// File: rtl/mpy_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mpy_seq_ctrl
//
// Operand-issue and result-capture sequencer for the external 32x32 signed
// combinational multiplier (MPY). The multiplier is instantiated beside this
// block. This block registers an operand pair, holds it on the MPY inputs for
// SETTLE_CYCLES clock cycles, samples the 64-bit product and presents it to
// the consumer over a valid/ready handshake.
//
// Parameters:
//   SETTLE_CYCLES  cycles the operands are held before sampling (1..255)
//   CNT_W          width of the completed-operation counter
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operand pair valid (upstream)
//   in_ready     block can accept an operand pair
//   in_a, in_b   two's complement operands
//   mpy_a, mpy_b registered operands driven to MPY
//   mpy_product  64-bit product returned from MPY
//   out_valid    result valid (downstream)
//   out_ready    consumer accepts result
//   out_product  registered product, passed through unchanged
//   out_ovf      product does not fit in signed 32 bits
//   busy         a transaction is in flight (settling or awaiting handoff)
//   op_count     number of completed output handshakes, wrapping
//
// Optional feature macro: MPY_OVF_FLAG_EN
//   Defined     : out_ovf is registered alongside out_product.
//   Not defined : out_ovf is tied to 0 and no compare logic is built.
// ---------------------------------------------------------------------------
module mpy_seq_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic [31:0]      mpy_a,
   output logic [31:0]      mpy_b,
   input  logic [63:0]      mpy_product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_product,
   output logic             out_ovf,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE
   } state_t;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     next_state;
   logic [7:0] settle_cnt;
   logic       accept;
   logic       capture;
   logic       handoff;

   // Next-state and handshake decode. An accept can happen either from IDLE
   // or from DONE in the same edge that hands the previous result off, which
   // is what gives back-to-back throughput of one op per SETTLE_CYCLES+1.
   // While DONE is stalled by the consumer, in_ready stays low so new operands
   // cannot disturb mpy_a/mpy_b.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      handoff    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               next_state = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == 8'd0) begin
               capture    = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               handoff = 1'b1;
               if (in_valid) begin
                  accept     = 1'b1;
                  next_state = SETTLE;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // State register. Reset drops any in-flight transaction immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Settle counter: loaded on accept so that the final SETTLE cycle is the
   // one where the count reaches zero; SETTLE_CYCLES=1 therefore gives a
   // single SETTLE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_cnt <= 8'd0;
      end else if (accept) begin
         settle_cnt <= SETTLE_LOAD;
      end else if ((state == SETTLE) && (settle_cnt != 8'd0)) begin
         settle_cnt <= settle_cnt - 8'd1;
      end
   end

   // Operand registers feed MPY directly and only move on an accept edge, so
   // the multiplier inputs are stable through SETTLE, DONE and IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mpy_a <= 32'd0;
         mpy_b <= 32'd0;
      end else if (accept) begin
         mpy_a <= in_a;
         mpy_b <= in_b;
      end
   end

   // Result register samples the product untouched in the last SETTLE cycle
   // and keeps its value after handoff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_product <= 64'd0;
      end else if (capture) begin
         out_product <= mpy_product;
      end
   end

   // Completed-operation counter counts output handshakes and wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (handoff) begin
         op_count <= op_count + 1'b1;
      end
   end

`ifdef MPY_OVF_FLAG_EN
   logic ovf_q;

   // The product fits in signed 32 bits exactly when bits 63..31 are all the
   // same (pure sign extension); anything else is flagged as overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (capture) begin
         ovf_q <= ~((&mpy_product[63:31]) | ~(|mpy_product[63:31]));
      end
   end

   assign out_ovf = ovf_q;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mpy_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mpy_seq_ctrl
//
// Self-checking bench for mpy_seq_ctrl with a behavioural 32x32 signed
// multiplier attached beside the DUT. A transaction-level reference model
// (one timestamped result in flight, a queue of expected products) predicts
// handshake signals, latency, operand stability, results and op_count.
// Honours MPY_OVF_FLAG_EN for the expected out_ovf.
// ---------------------------------------------------------------------------
module tb_mpy_seq_ctrl;

   localparam int SETTLE = 2;
   localparam int CNT_W  = 16;

   typedef struct {
      logic [63:0] product;
      logic        ovf;
   } result_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [31:0]      mpy_a;
   logic [31:0]      mpy_b;
   logic [63:0]      mpy_product;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_product;
   logic             out_ovf;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   int vectors    = 0;
   int miscompares = 0;
   int cyc;

   result_t          sb[$];
   bit               have_item;
   int               valid_at;
   logic [31:0]      last_a;
   logic [31:0]      last_b;
   logic [63:0]      last_prod;
   logic             last_ovf;
   logic [CNT_W-1:0] exp_count;

   mpy_seq_ctrl #(
      .SETTLE_CYCLES(SETTLE),
      .CNT_W        (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mpy_a      (mpy_a),
      .mpy_b      (mpy_b),
      .mpy_product(mpy_product),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_product(out_product),
      .out_ovf    (out_ovf),
      .busy       (busy),
      .op_count   (op_count)
   );

   // Stand-in for the MPY block that sits beside the sequencer.
   assign mpy_product = 64'(longint'($signed(mpy_a)) * longint'($signed(mpy_b)));

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to timestamp accepts for the latency model.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc <= 0;
      end else begin
         cyc <= cyc + 1;
      end
   end

   // Compares one value, bumps the counters and reports a miscompare.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected result of one operand pair from plain signed arithmetic.
   function automatic result_t refModel(input logic [31:0] a, input logic [31:0] b);
      result_t r;
      longint  p;
      p = longint'($signed(a)) * longint'($signed(b));
      r.product = 64'(p);
`ifdef MPY_OVF_FLAG_EN
      r.ovf = (p < -64'sd2147483648) || (p > 64'sd2147483647);
`else
      r.ovf = 1'b0;
`endif
      return r;
   endfunction

   // Monitor and scoreboard: on every falling edge, predict what the DUT
   // should present, compare, then advance the model by the handshakes that
   // will occur on the next rising edge.
   always @(negedge clk) begin
      bit      exp_valid;
      bit      exp_in_ready;
      result_t r;
      if (rst) begin
         sb.delete();
         have_item = 1'b0;
         last_a    = '0;
         last_b    = '0;
         last_prod = '0;
         last_ovf  = 1'b0;
         exp_count = '0;
         checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
         checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
         checkOutput("rst_busy", 64'(busy), 64'd0);
         checkOutput("rst_mpy_a", 64'(mpy_a), 64'd0);
         checkOutput("rst_out_product", out_product, 64'd0);
         checkOutput("rst_op_count", 64'(op_count), 64'd0);
      end else begin
         exp_valid    = have_item && (cyc >= valid_at);
         exp_in_ready = !have_item || (exp_valid && out_ready);
         checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
         checkOutput("in_ready", 64'(in_ready), 64'(exp_in_ready));
         checkOutput("busy", 64'(busy), 64'(have_item));
         checkOutput("mpy_a", 64'(mpy_a), 64'(last_a));
         checkOutput("mpy_b", 64'(mpy_b), 64'(last_b));
         checkOutput("op_count", 64'(op_count), 64'(exp_count));
         if (exp_valid) begin
            if (sb.size() == 0) begin
               checkOutput("sb_underflow", 64'd0, 64'd1);
            end else begin
               checkOutput("out_product", out_product, sb[0].product);
               checkOutput("out_ovf", 64'(out_ovf), 64'(sb[0].ovf));
            end
         end else begin
            checkOutput("out_product_hold", out_product, last_prod);
            checkOutput("out_ovf_hold", 64'(out_ovf), 64'(last_ovf));
         end
         if (exp_valid && out_ready) begin
            r         = sb.pop_front();
            last_prod = r.product;
            last_ovf  = r.ovf;
            have_item = 1'b0;
            exp_count = exp_count + 1'b1;
         end
         if (in_valid && exp_in_ready) begin
            sb.push_back(refModel(in_a, in_b));
            have_item = 1'b1;
            valid_at  = cyc + 1 + SETTLE;
            last_a    = in_a;
            last_b    = in_b;
         end
      end
   end

   // Presents one operand pair and holds it until the DUT takes it.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
   endtask

   // Operand picker biased toward sign and overflow corners.
   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 100));
         default: return 32'($urandom);
      endcase
   endfunction

   // Directed scenarios first, then randomized traffic, then drain.
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      out_ready = 1'b1;
      applyStimulus(32'd3, 32'd5);
      applyStimulus(32'hFFFF_FFFE, 32'd3);
      applyStimulus(32'h8000_0000, 32'h8000_0000);
      repeat (4) @(posedge clk);
      #1;

      out_ready = 1'b0;
      applyStimulus(32'd3, 32'd5);
      in_valid = 1'b1;
      in_a     = 32'd7;
      in_b     = 32'd2;
      repeat (SETTLE + 5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      applyStimulus(32'd7, 32'd2);
      repeat (4) @(posedge clk);
      #1;

      for (int i = 0; i < 4; i++) begin
         applyStimulus(pickOperand(), pickOperand());
      end
      repeat (4) @(posedge clk);
      #1;

      applyStimulus(32'd9, 32'd11);
      rst = 1'b1;
      #1;
      checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("async_rst_busy", 64'(busy), 64'd0);
      checkOutput("async_rst_mpy_a", 64'(mpy_a), 64'd0);
      checkOutput("async_rst_op_count", 64'(op_count), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = pickOperand();
         in_b      = pickOperand();
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (SETTLE + 6) @(posedge clk);
      #1;
      checkOutput("drain_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
